dadda_mul_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one WIDTH x WIDTH multiplier instance (e.g. dadda_8, exact or approximate) between NREQ requesters.
- Accepts operand pairs over per-requester valid/ready, drives the shared multiplier's operand inputs, and waits a fixed settle time.
- Captures the {upper, lower} product and returns it with the requester ID over a single valid/ready response channel.

---
 rtl/dadda_mul_arbiter.sv | 155 +++++++++++++++
 tb/tb_dadda_mul_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dadda_mul_arbiter.sv
// Round-robin sharing of one WIDTH x WIDTH multiplier among NREQ requesters; DADDA_ARB_ERR_MON_EN adds an exact-product error monitor.
// Latency: response valid MUL_LAT+1 cycles after the request handshake; one operation per MUL_LAT+2 cycles at best.
// Backpressure: a stalled response holds the sequencer in RESP and keeps every req_ready low until rsp_ready.
module dadda_mul_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*WIDTH-1:0]     req_a,
    input  logic [NREQ*WIDTH-1:0]     req_b,
    output logic [WIDTH-1:0]          mul_in1,
    output logic [WIDTH-1:0]          mul_in2,
    input  logic [WIDTH-1:0]          mul_lo,
    input  logic [WIDTH-1:0]          mul_hi,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [2*WIDTH-1:0]        rsp_prod,
    output logic                      busy,
    output logic [15:0]               err_cnt
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MUL_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDW-1:0]   rr_ptr;
    logic [CW-1:0]    wait_cnt;

    logic             grant_vld;
    logic [IDW-1:0]   grant_idx;
    logic [WIDTH-1:0] grant_a;
    logic [WIDTH-1:0] grant_b;
    logic             grant_take;
    logic             capture;
    logic             rsp_take;

    // Search starts at rr_ptr and wraps; the first asserted requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        grant_a   = '0;
        grant_b   = '0;
        for (int k = 0; k < NREQ; k++) begin
            int cand;
            cand = int'(rr_ptr) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = IDW'(cand);
                grant_a   = req_a[cand*WIDTH +: WIDTH];
                grant_b   = req_b[cand*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        grant_take = 1'b0;
        capture    = 1'b0;
        rsp_take   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    // Held low while reset is asserted so no handshake is seen mid-reset.
                    req_ready[grant_idx] = rst_n;
                    grant_take           = 1'b1;
                    state_d              = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == CW'(1)) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_take = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            wait_cnt  <= '0;
            mul_in1   <= '0;
            mul_in2   <= '0;
            rsp_id    <= '0;
            rsp_prod  <= '0;
            rsp_valid <= 1'b0;
        end else begin
            if (grant_take) begin
                mul_in1  <= grant_a;
                mul_in2  <= grant_b;
                rsp_id   <= grant_idx;
                wait_cnt <= CW'(MUL_LAT);
                rr_ptr   <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
            end
            if (state_q == ST_WAIT && !capture) begin
                wait_cnt <= wait_cnt - CW'(1);
            end
            if (capture) begin
                rsp_prod  <= {mul_hi, mul_lo};
                rsp_valid <= 1'b1;
            end
            if (rsp_take) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef DADDA_ARB_ERR_MON_EN
    logic [2*WIDTH-1:0] ref_prod;
    logic [15:0]        err_cnt_q;

    assign ref_prod = mul_in1 * mul_in2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (capture && (ref_prod != {mul_hi, mul_lo}) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_dadda_mul_arbiter.sv
// Bench for dadda_mul_arbiter: directed scenarios then randomized traffic against a cycle-timeline model.
// Latency: expects responses MUL_LAT+1 cycles after each grant; the multiplier model is combinational.
// Backpressure: rsp_ready is stalled both deterministically and randomly.
module tb_dadda_mul_arbiter;

    localparam int W   = 8;
    localparam int N   = 4;
    localparam int LAT = 1;

    logic               clk;
    logic               rst_n;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*W-1:0]     req_a;
    logic [N*W-1:0]     req_b;
    logic [W-1:0]       mul_in1;
    logic [W-1:0]       mul_in2;
    logic [W-1:0]       mul_lo;
    logic [W-1:0]       mul_hi;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [$clog2(N)-1:0] rsp_id;
    logic [2*W-1:0]     rsp_prod;
    logic               busy;
    logic [15:0]        err_cnt;

    logic               flip;
    logic [2*W-1:0]     mul_full;

    int n_assert = 0;
    int n_fail   = 0;

    dadda_mul_arbiter #(.WIDTH(W), .NREQ(N), .MUL_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_in1(mul_in1), .mul_in2(mul_in2),
        .mul_lo(mul_lo), .mul_hi(mul_hi),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_prod(rsp_prod),
        .busy(busy), .err_cnt(err_cnt)
    );

    // Shared multiplier: exact product, optionally with lower bit 0 corrupted.
    assign mul_full = (16'(mul_in1) * 16'(mul_in2)) ^ {15'd0, flip};
    assign mul_lo   = mul_full[W-1:0];
    assign mul_hi   = mul_full[2*W-1:W];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_valid[i]       = 1'b1;
        req_a[i*W +: W]    = W'(a);
        req_b[i*W +: W]    = W'(b);
    endtask

    // Waits for the grant, checks it and the response, then completes the handshake.
    task automatic serve(input int g, input logic [15:0] p, input int stall);
        int n;
        rsp_ready = 1'b0;
        #1;
        n = 0;
        while (req_ready == '0 && n < 20) begin
            step(); #1; n++;
        end
        chk("grant", req_ready, 32'(1 << g));
        step();
        req_valid[g] = 1'b0;
        #1;
        n = 0;
        while (!rsp_valid && n < 20) begin
            chk("wait_rdy", req_ready, 0);
            chk("wait_busy", busy, 1);
            step(); #1; n++;
        end
        chk("rsp_lat", n, LAT);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, g);
        chk("rsp_prod", rsp_prod, p);
        for (int s = 0; s < stall; s++) begin
            step(); #1;
            chk("stall_valid", rsp_valid, 1);
            chk("stall_prod", rsp_prod, p);
            chk("stall_rdy", req_ready, 0);
            chk("stall_busy", busy, 1);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        chk("post_busy", busy, 0);
        chk("post_valid", rsp_valid, 0);
    endtask

    initial begin
        int ptr_m;
        int g;
        int gnow;
        int age;
        int n;
        bit outst;
        logic [W-1:0]   ea, eb;
        logic [2*W-1:0] ep;

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0; flip = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_in1", mul_in1, 0);
        chk("rst_in2", mul_in2, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_prod", rsp_prod, 0);
        chk("rst_err", err_cnt, 0);
        step(); step();
        rst_n = 1'b1;
        step();

        // All four pending: strict rotation 0..3, then the pointer wraps back to 0.
        for (int i = 0; i < N; i++) set_op(i, i + 1, 10);
        for (int i = 0; i < N; i++) serve(i, 16'((i + 1) * 10), 0);
        for (int i = 0; i < N; i++) set_op(i, i + 1, 10);
        serve(0, 16'd10, 0);
        req_valid = '0;

        set_op(0, 2, 4);
        serve(0, 16'd8, 0);
        chk("in1_hold", mul_in1, 2);
        chk("in2_hold", mul_in2, 4);

        // Pointer is at 1: requester 0 alone, then {0,2}, then 1 joins.
        set_op(0, 5, 6);
        serve(0, 16'd30, 0);
        set_op(0, 7, 8);
        set_op(2, 9, 9);
        serve(2, 16'd81, 0);
        set_op(1, 2, 3);
        serve(0, 16'd56, 0);
        serve(1, 16'd6, 0);

        set_op(0, 255, 255);
        serve(0, 16'hFE01, 5);

        // Reset during WAIT on requester 2 (pointer would become 3).
        set_op(2, 3, 5);
        #1;
        chk("rstw_grant", req_ready, 32'h4);
        step();
        req_valid = '0;
        #1;
        chk("rstw_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rstw_valid", rsp_valid, 0);
        chk("rstw_busy0", busy, 0);
        chk("rstw_in1", mul_in1, 0);
        chk("rstw_in2", mul_in2, 0);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rstw_stale", rsp_valid, 0);
            chk("rstw_idle", busy, 0);
        end
        for (int i = 0; i < N; i++) set_op(i, i + 20, 3);
        serve(0, 16'd60, 0);
        req_valid = '0;
        ptr_m = 1;

        // Randomized traffic against a grant-timeline model.
        outst = 1'b0;
        age = 0; ea = '0; eb = '0; ep = '0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom % 4 == 0)) begin
                    set_op(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
                end else if (req_valid[i] && ($urandom % 16 == 0)) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom % 3 != 0);
            #1;
            gnow = -1;
            if (outst) begin
                age++;
                chk("r_busy", busy, 1);
                chk("r_rdy", req_ready, 0);
                chk("r_in1", mul_in1, ea);
                chk("r_in2", mul_in2, eb);
                chk("r_valid", rsp_valid, (age > LAT));
                if (age > LAT) begin
                    chk("r_id", rsp_id, g);
                    chk("r_prod", rsp_prod, ep);
                    if (rsp_ready) outst = 1'b0;
                end
            end else begin
                chk("r_idle_busy", busy, 0);
                chk("r_idle_valid", rsp_valid, 0);
                gnow = -1;
                for (int k = 0; k < N; k++) begin
                    if (gnow < 0 && req_valid[(ptr_m + k) % N]) gnow = (ptr_m + k) % N;
                end
                if (gnow >= 0) begin
                    chk("r_grant", req_ready, 32'(1 << gnow));
                    g     = gnow;
                    ea    = req_a[gnow*W +: W];
                    eb    = req_b[gnow*W +: W];
                    ep    = 16'(ea) * 16'(eb);
                    ptr_m = (gnow + 1) % N;
                    outst = 1'b1;
                    age   = 0;
                end else begin
                    chk("r_nogrant", req_ready, 0);
                end
            end
            step();
            if (gnow >= 0) req_valid[gnow] = 1'b0;
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        n = 0;
        while (busy && n < 20) begin
            step(); n++;
        end
        chk("drain", busy, 0);
        rsp_ready = 1'b0;
        chk("err_before", err_cnt, 0);

        // Lower bit corrupted on operations 0, 2 and 4.
        for (int op = 0; op < 5; op++) begin
            flip = (op % 2 == 0);
            set_op(0, op + 3, op + 7);
            serve(0, 16'((op + 3) * (op + 7)) ^ {15'd0, flip}, 0);
        end
        flip = 1'b0;
`ifdef DADDA_ARB_ERR_MON_EN
        chk("err_cnt", err_cnt, 3);
`else
        chk("err_cnt", err_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
